// File: rtl/arb_mux_pkg.sv
// Shared types and default sizing for the arb_mux round-robin arbitrating mux.
package arb_mux_pkg;

  typedef enum logic {
    Empty = 1'b0,
    Full  = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultN     = 4;
  localparam int unsigned MaxN         = 16;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant: first requester at ptr, ptr+1, ... wrapping modulo N.
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned SELW = $clog2(N);

  // One spare bit so ptr + i can exceed N-1 before the modulo fold.
  logic [SELW:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (SELW+1)'(i);
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
      if (!found && req[cand[SELW-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SELW-1:0]]   = 1'b1;
        idx                     = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Round-robin N:1 arbitrating mux feeding one registered output slot (EMPTY/FULL).
// Define ARB_MUX_HOLD_EN to add a hold input that locks the grant to the last-served channel.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N     = DefaultN
) (
  input  logic                    clk,
  input  logic                    reset_n,
`ifdef ARB_MUX_HOLD_EN
  input  logic                    hold,
`endif
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N)-1:0]    out_sel,
  input  logic                    out_ready
);

  localparam int unsigned SELW = $clog2(N);

  if (N < 2 || N > MaxN) begin : gen_bad_n
    $error("arb_mux: N must be in 2..%0d", MaxN);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  gnt_idx;
  logic [N-1:0]     req, grant;
  logic             can_accept, xfer, hold_act;

`ifdef ARB_MUX_HOLD_EN
  // sel_q only names a real channel once something has been transferred since reset.
  logic served_q;

  assign hold_act = hold & served_q;
  assign req      = hold_act ? (in_valid & (N'(1) << sel_q)) : in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      served_q <= 1'b0;
    end else if (xfer) begin
      served_q <= 1'b1;
    end
  end
`else
  assign hold_act = 1'b0;
  assign req      = in_valid;
`endif

  rr_arb #(
    .N (N)
  ) u_rr_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign can_accept = (state_q == Empty) | out_ready;
  assign in_ready   = can_accept ? grant : '0;
  assign xfer       = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = Full;
      data_d  = in_data[gnt_idx];
      sel_d   = gnt_idx;
      if (!hold_act) begin
        ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end else if (state_q == Full && out_ready) begin
      state_d = Empty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Empty;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == Full);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: vector table, corner sequences, randomized model check.
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [3:0]      iv;
  logic [3:0][7:0] idat;
  logic [3:0]      ird;
  logic            ov;
  logic [7:0]      od;
  logic [1:0]      os;
  logic            ordy;

  logic [2:0]      iv3;
  logic [2:0][7:0] idat3;
  logic [2:0]      ird3;
  logic            ov3;
  logic [7:0]      od3;
  logic [1:0]      os3;
  logic            ordy3;

`ifdef ARB_MUX_HOLD_EN
  logic hold;
  logic hold3;
`endif

  arb_mux #(.WIDTH(8), .N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef ARB_MUX_HOLD_EN
    .hold      (hold),
`endif
    .in_valid  (iv),
    .in_data   (idat),
    .in_ready  (ird),
    .out_valid (ov),
    .out_data  (od),
    .out_sel   (os),
    .out_ready (ordy)
  );

  arb_mux #(.WIDTH(8), .N(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef ARB_MUX_HOLD_EN
    .hold      (hold3),
`endif
    .in_valid  (iv3),
    .in_data   (idat3),
    .in_ready  (ird3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_ready (ordy3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl[15];

  // Reference model state for the N=4 instance.
  bit       m_full;
  bit [7:0] m_data;
  int       m_sel;
  int       m_ptr;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    iv    = '0;
    ordy  = 1'b0;
    iv3   = '0;
    ordy3 = 1'b0;
`ifdef ARB_MUX_HOLD_EN
    hold  = 1'b0;
    hold3 = 1'b0;
`endif
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive-then-check one cycle of the N=4 instance (inputs already set, clk low).
  task automatic cyc4(input string name, input logic [3:0] exp_rdy, input logic exp_ov,
                      input logic [1:0] exp_sel, input logic [7:0] exp_data);
    #1;
    chk({name, "_in_ready"}, ird, exp_rdy);
    @(posedge clk);
    #1;
    chk({name, "_out_valid"}, ov, exp_ov);
    if (exp_ov) begin
      chk({name, "_out_sel"}, os, exp_sel);
      chk({name, "_out_data"}, od, exp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    int   g;
    bit   acc;
    logic [3:0] exp_rdy;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

    for (int ch = 0; ch < 4; ch++) idat[ch] = 8'h10 + 8'(ch);
    idat3 = '0;

    // Reset state
    do_reset();
    #1;
    chk("reset_out_valid", ov, 1'b0);
    chk("reset_out_sel", os, 2'd0);
    chk("reset_out_data", od, 8'h00);
    chk("reset_in_ready_idle", ird, 4'b0000);
    @(negedge clk);

    // Vector table: round-robin sweep, drain, backpressure, wrap, single requester
    for (int i = 0; i < 15; i++) begin
      iv   = tbl[i].valid;
      ordy = tbl[i].ordy;
      cyc4($sformatf("vec%0d", i), tbl[i].exp_rdy, tbl[i].exp_ov, tbl[i].exp_sel,
           8'h10 + 8'(tbl[i].exp_sel));
    end

    // Backpressure holds an A5 beat from ch2
    idat[2] = 8'hA5;
    iv      = 4'b0100;
    ordy    = 1'b0;
    cyc4("bp_load", 4'b0100, 1'b1, 2'd2, 8'hA5);
    iv = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc4($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 2'd2, 8'hA5);
    end
    ordy = 1'b1;
    cyc4("bp_release", 4'b1000, 1'b1, 2'd3, 8'h13);
    idat[2] = 8'h12;

    // Asynchronous reset mid-beat, then search restarts at channel 0
    iv = 4'b0010;
    cyc4("ar_load", 4'b0010, 1'b1, 2'd1, 8'h11);
    iv = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", ov, 1'b0);
    chk("ar_out_sel", os, 2'd0);
    chk("ar_out_data", od, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    iv      = 4'b1111;
    ordy    = 1'b1;
    cyc4("ar_first", 4'b0001, 1'b1, 2'd0, 8'h10);
    iv = 4'b0000;

    // N=3 wrap: ptr=2 with ch0/ch1 requesting grants ch0, ptr becomes 1
    ordy3 = 1'b1;
    for (int ch = 0; ch < 3; ch++) idat3[ch] = 8'h30 + 8'(ch);
    iv3 = 3'b010;
    #1;
    chk("n3_first_in_ready", ird3, 3'b010);
    @(posedge clk);
    #1;
    chk("n3_first_out_sel", os3, 2'd1);
    @(negedge clk);
    iv3 = 3'b011;
    #1;
    chk("n3_wrap_in_ready", ird3, 3'b001);
    @(posedge clk);
    #1;
    chk("n3_wrap_out_sel", os3, 2'd0);
    chk("n3_wrap_out_data", od3, 8'h30);
    @(negedge clk);
    #1;
    chk("n3_after_wrap_in_ready", ird3, 3'b010);
    @(posedge clk);
    #1;
    chk("n3_after_wrap_out_sel", os3, 2'd1);
    @(negedge clk);
    iv3 = 3'b000;

`ifdef ARB_MUX_HOLD_EN
    // Hold locks the grant to ch3, release resumes at ch0
    do_reset();
    iv   = 4'b1000;
    ordy = 1'b1;
    cyc4("hold_seed", 4'b1000, 1'b1, 2'd3, 8'h13);
    hold = 1'b1;
    iv   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc4($sformatf("hold_beat%0d", i), 4'b1000, 1'b1, 2'd3, 8'h13);
    end
    hold = 1'b0;
    cyc4("hold_release", 4'b0001, 1'b1, 2'd0, 8'h10);
`endif

    // Randomized traffic against the reference model
    do_reset();
    m_full = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_ptr  = 0;
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!iv[ch] && $urandom_range(0, 99) < 60) begin
          iv[ch]   = 1'b1;
          idat[ch] = 8'($urandom);
        end
      end
      ordy    = ($urandom_range(0, 99) < 70);
      g       = pick(iv, m_ptr);
      acc     = (g >= 0) && (!m_full || ordy);
      exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
      #1;
      chk("rand_in_ready", ird, exp_rdy);
      @(posedge clk);
      if (acc) begin
        m_full = 1'b1;
        m_data = idat[g];
        m_sel  = g;
        m_ptr  = (g + 1) % 4;
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
      #1;
      chk("rand_out_valid", ov, m_full);
      if (m_full) begin
        chk("rand_out_sel", os, m_sel);
        chk("rand_out_data", od, m_data);
      end
      @(negedge clk);
      if (acc) iv[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
